// File: rtl/bsg_mcl_gearbox_pkg.sv
// rtl/bsg_mcl_gearbox_pkg.sv - shared widths and word/packet slicing helpers for the MCL gearbox
package bsg_mcl_gearbox_pkg;

  localparam int host_word_width_gp = 32;
  localparam int max_mcl_width_gp   = 1024;

  function automatic int mcl_ratio(input int width);
    return width / host_word_width_gp;
  endfunction

  // Bit-slot of host word idx inside a packet of ratio words.
  function automatic int word_pos(input int idx, input bit lsb_first, input int ratio);
    return lsb_first ? idx : ratio - 1 - idx;
  endfunction

  function automatic logic [host_word_width_gp-1:0] word_slice(
      input logic [max_mcl_width_gp-1:0] packet, input int idx, input bit lsb_first, input int ratio);
    return packet[word_pos(idx, lsb_first, ratio)*host_word_width_gp +: host_word_width_gp];
  endfunction

endpackage

// File: rtl/bsg_mcl_host_gearbox_if.sv
// rtl/bsg_mcl_host_gearbox_if.sv - host word and MCL packet handshakes of the gearbox
interface bsg_mcl_host_gearbox_if
  import bsg_mcl_gearbox_pkg::*;
  #(parameter int mcl_width_p = 128,
    parameter int rcv_els_p   = 256);

  localparam int ratio_lp      = mcl_ratio(mcl_width_p);
  localparam int pend_width_lp = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
  localparam int vac_width_lp  = $clog2(rcv_els_p + 1);

  logic                          host_tx_v_i;
  logic [host_word_width_gp-1:0] host_tx_data_i;
  logic                          host_tx_ready_o;
  logic                          tx_flush_i;
  logic                          mcl_v_o;
  logic [mcl_width_p-1:0]        mcl_data_o;
  logic                          mcl_r_i;
  logic                          mcl_v_i;
  logic [mcl_width_p-1:0]        mcl_data_i;
  logic                          mcl_r_o;
  logic                          host_rx_v_o;
  logic [host_word_width_gp-1:0] host_rx_data_o;
  logic                          host_rx_yumi_i;
  logic [vac_width_lp-1:0]       rcv_vacancy_o;
  logic [pend_width_lp-1:0]      tx_words_pending_o;

  modport master (
    output host_tx_v_i, host_tx_data_i, tx_flush_i, mcl_r_i, mcl_v_i, mcl_data_i, host_rx_yumi_i,
    input  host_tx_ready_o, mcl_v_o, mcl_data_o, mcl_r_o, host_rx_v_o, host_rx_data_o,
           rcv_vacancy_o, tx_words_pending_o
  );

  modport slave (
    input  host_tx_v_i, host_tx_data_i, tx_flush_i, mcl_r_i, mcl_v_i, mcl_data_i, host_rx_yumi_i,
    output host_tx_ready_o, mcl_v_o, mcl_data_o, mcl_r_o, host_rx_v_o, host_rx_data_o,
           rcv_vacancy_o, tx_words_pending_o
  );

endinterface

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small one-read one-write FIFO, ready_o independent of yumi_i
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] els_lp      = cnt_width_lp'(els_p);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [cnt_width_lp-1:0] count_r;
  logic                    enq, deq;

  assign ready_o = (count_r != els_lp);
  assign v_o     = (count_r != '0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_r[rd_ptr_r];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) wr_ptr_r <= (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + 1'b1;
      if (deq) rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + 1'b1;
      if (enq & ~deq)      count_r <= count_r + 1'b1;
      else if (deq & ~enq) count_r <= count_r - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_mcl_host_gearbox_word_packer.sv
// rtl/bsg_mcl_host_gearbox_word_packer.sv - TX assembly of host words into one registered MCL packet
module bsg_mcl_word_packer
  import bsg_mcl_gearbox_pkg::*;
#(
    parameter int mcl_width_p = 128,
    parameter bit lsb_first_p = 1'b1,
    localparam int ratio_lp     = mcl_ratio(mcl_width_p),
    localparam int cnt_width_lp = (ratio_lp > 1) ? $clog2(ratio_lp) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          v_i,
    input  logic [host_word_width_gp-1:0] data_i,
    output logic                          ready_o,
    input  logic                          flush_i,
    output logic                          v_o,
    output logic [mcl_width_p-1:0]        data_o,
    input  logic                          ready_i,
    output logic [cnt_width_lp-1:0]       cnt_o
);

  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(ratio_lp - 1);

  logic [cnt_width_lp-1:0] cnt_r;
  logic [mcl_width_p-1:0]  asm_r, data_r, pkt_n;
  logic                    out_v_r, last_word, accept;
  int                      wr_pos;

  assign last_word = (cnt_r == last_cnt_lp);
  assign ready_o   = ~flush_i & (~last_word | ~out_v_r | ready_i);
  assign accept    = v_i & ready_o;
  assign wr_pos    = word_pos(int'(cnt_r), lsb_first_p, ratio_lp);

  // The assembly image with the incoming word merged in; on the last word this is the packet.
  always_comb begin
    pkt_n = asm_r;
    pkt_n[wr_pos*host_word_width_gp +: host_word_width_gp] = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r   <= '0;
      out_v_r <= 1'b0;
    end else begin
      if (accept & last_word) out_v_r <= 1'b1;
      else if (ready_i)       out_v_r <= 1'b0;
      if (flush_i)     cnt_r <= '0;
      else if (accept) cnt_r <= last_word ? '0 : cnt_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (last_word) data_r <= pkt_n;
      else           asm_r  <= pkt_n;
    end
  end

  assign v_o    = out_v_r;
  assign data_o = data_r;
  assign cnt_o  = cnt_r;

endmodule

// File: rtl/bsg_mcl_host_gearbox.sv
// rtl/bsg_mcl_host_gearbox.sv - host word <-> MCL packet gearbox with RX packet buffering
module bsg_mcl_host_gearbox
  import bsg_mcl_gearbox_pkg::*;
#(
    parameter int mcl_width_p = 128,
    parameter int rcv_els_p   = 256,
    parameter bit lsb_first_p = 1'b1
) (
    input logic clk_i,
    input logic reset_i,
    bsg_mcl_host_gearbox_if.slave io
);

  localparam int ratio_lp     = mcl_ratio(mcl_width_p);
  localparam int idx_width_lp = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
  localparam int vac_width_lp = $clog2(rcv_els_p + 1);
  localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(ratio_lp - 1);
  localparam logic [vac_width_lp-1:0] full_vac_lp = vac_width_lp'(rcv_els_p);

  if ((mcl_width_p % host_word_width_gp) != 0 || mcl_width_p < host_word_width_gp
      || mcl_width_p > max_mcl_width_gp) begin : g_bad_width
    $error("mcl_width_p must be a multiple of 32 between 32 and 1024");
  end
  if (rcv_els_p < 2) begin : g_bad_depth
    $error("rcv_els_p must be at least 2");
  end

  bsg_mcl_word_packer #(.mcl_width_p(mcl_width_p), .lsb_first_p(lsb_first_p)) packer (
    .clk_i, .reset_i,
    .v_i(io.host_tx_v_i), .data_i(io.host_tx_data_i), .ready_o(io.host_tx_ready_o),
    .flush_i(io.tx_flush_i),
    .v_o(io.mcl_v_o), .data_o(io.mcl_data_o), .ready_i(io.mcl_r_i),
    .cnt_o(io.tx_words_pending_o)
  );

  logic                        fifo_v, fifo_ready, rx_yumi, rx_deq, rx_enq;
  logic [mcl_width_p-1:0]      head;
  logic [max_mcl_width_gp-1:0] head_ext;
  logic [idx_width_lp-1:0]     rx_idx_r;
  logic [vac_width_lp-1:0]     vacancy_r;

  bsg_fifo_1r1w_small #(.width_p(mcl_width_p), .els_p(rcv_els_p)) rx_fifo (
    .clk_i, .reset_i,
    .v_i(io.mcl_v_i), .ready_o(fifo_ready), .data_i(io.mcl_data_i),
    .v_o(fifo_v), .data_o(head), .yumi_i(rx_deq)
  );

  // A stray yumi on an empty FIFO is masked so it cannot corrupt rx_idx or vacancy.
  assign rx_yumi = io.host_rx_yumi_i & fifo_v;
  assign rx_deq  = rx_yumi & (rx_idx_r == last_idx_lp);
  assign rx_enq  = io.mcl_v_i & fifo_ready;

  always_comb begin
    head_ext = '0;
    head_ext[mcl_width_p-1:0] = head;
  end

  assign io.mcl_r_o        = fifo_ready;
  assign io.host_rx_v_o    = fifo_v;
  assign io.host_rx_data_o = word_slice(head_ext, int'(rx_idx_r), lsb_first_p, ratio_lp);
  assign io.rcv_vacancy_o  = vacancy_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_idx_r  <= '0;
      vacancy_r <= full_vac_lp;
    end else begin
      if (rx_deq)       rx_idx_r <= '0;
      else if (rx_yumi) rx_idx_r <= rx_idx_r + 1'b1;
      if (rx_enq & ~rx_deq)      vacancy_r <= vacancy_r - 1'b1;
      else if (rx_deq & ~rx_enq) vacancy_r <= vacancy_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && io.host_rx_yumi_i)
      assert (fifo_v) else $error("host_rx_yumi_i asserted while RX FIFO is empty");
  end

endmodule

// File: tb/tb_bsg_mcl_host_gearbox.sv
// tb/tb_bsg_mcl_host_gearbox.sv - scoreboard bench for the gearbox across four configurations
module tb_bsg_mcl_host_gearbox;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [127:0] txq0[$], txq1[$];
  logic [31:0]  rxq0[$], rxq1[$], rxq2[$], txq3[$], rxq3[$];

  bsg_mcl_host_gearbox_if #(.mcl_width_p(128), .rcv_els_p(256)) if0 ();
  bsg_mcl_host_gearbox_if #(.mcl_width_p(128), .rcv_els_p(256)) if1 ();
  bsg_mcl_host_gearbox_if #(.mcl_width_p(128), .rcv_els_p(4))   if2 ();
  bsg_mcl_host_gearbox_if #(.mcl_width_p(32),  .rcv_els_p(4))   if3 ();

  bsg_mcl_host_gearbox #(.mcl_width_p(128), .rcv_els_p(256), .lsb_first_p(1'b1)) dut0 (.clk_i(clk), .reset_i(rst), .io(if0));
  bsg_mcl_host_gearbox #(.mcl_width_p(128), .rcv_els_p(256), .lsb_first_p(1'b0)) dut1 (.clk_i(clk), .reset_i(rst), .io(if1));
  bsg_mcl_host_gearbox #(.mcl_width_p(128), .rcv_els_p(4),   .lsb_first_p(1'b1)) dut2 (.clk_i(clk), .reset_i(rst), .io(if2));
  bsg_mcl_host_gearbox #(.mcl_width_p(32),  .rcv_els_p(4),   .lsb_first_p(1'b1)) dut3 (.clk_i(clk), .reset_i(rst), .io(if3));

  function automatic logic [31:0] word(input logic [31:0] base, input logic [31:0] step, input int i);
    return base + step * i;
  endfunction

  // Reference packing: host word i at bits [32i+:32] (lsb first) or mirrored (msb first).
  function automatic logic [127:0] pack4(input logic [31:0] base, input logic [31:0] step, input bit lsb);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (lsb) p[i*32 +: 32] = word(base, step, i);
      else     p[(3-i)*32 +: 32] = word(base, step, i);
    end
    return p;
  endfunction

  task automatic test_reset;
    if0.host_tx_v_i = 0; if0.host_tx_data_i = '0; if0.tx_flush_i = 0; if0.mcl_r_i = 0; if0.mcl_v_i = 0; if0.mcl_data_i = '0; if0.host_rx_yumi_i = 0;
    if1.host_tx_v_i = 0; if1.host_tx_data_i = '0; if1.tx_flush_i = 0; if1.mcl_r_i = 0; if1.mcl_v_i = 0; if1.mcl_data_i = '0; if1.host_rx_yumi_i = 0;
    if2.host_tx_v_i = 0; if2.host_tx_data_i = '0; if2.tx_flush_i = 0; if2.mcl_r_i = 0; if2.mcl_v_i = 0; if2.mcl_data_i = '0; if2.host_rx_yumi_i = 0;
    if3.host_tx_v_i = 0; if3.host_tx_data_i = '0; if3.tx_flush_i = 0; if3.mcl_r_i = 0; if3.mcl_v_i = 0; if3.mcl_data_i = '0; if3.host_rx_yumi_i = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++; if (if0.rcv_vacancy_o !== 9'd256) $display("FAIL reset_vacancy: got %0d want 256", if0.rcv_vacancy_o); else passed++;
    checks++; if (if0.mcl_v_o !== 1'b0) $display("FAIL reset_mcl_v: got %b want 0", if0.mcl_v_o); else passed++;
    checks++; if (if0.host_rx_v_o !== 1'b0) $display("FAIL reset_rx_v: got %b want 0", if0.host_rx_v_o); else passed++;
    checks++; if (if0.mcl_r_o !== 1'b1) $display("FAIL reset_mcl_r: got %b want 1", if0.mcl_r_o); else passed++;
    checks++; if (if0.tx_words_pending_o !== 2'd0) $display("FAIL reset_pending: got %0d want 0", if0.tx_words_pending_o); else passed++;
    checks++; if (if2.rcv_vacancy_o !== 3'd4) $display("FAIL reset_vacancy_small: got %0d want 4", if2.rcv_vacancy_o); else passed++;
  endtask

  task automatic test_tx_pack;
    if0.mcl_r_i = 1; if1.mcl_r_i = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if0.host_tx_v_i = 1; if0.host_tx_data_i = word(32'h11111111, 32'h11111111, i);
      if1.host_tx_v_i = 1; if1.host_tx_data_i = word(32'h11111111, 32'h11111111, i);
      if (i == 3) begin
        txq0.push_back(pack4(32'h11111111, 32'h11111111, 1'b1));
        txq1.push_back(pack4(32'h11111111, 32'h11111111, 1'b0));
      end
      @(negedge clk);
      checks++; if (if0.tx_words_pending_o !== 2'(i)) $display("FAIL pack_pending[%0d]: got %0d want %0d", i, if0.tx_words_pending_o, i); else passed++;
      checks++; if (if0.host_tx_ready_o !== 1'b1 || if1.host_tx_ready_o !== 1'b1) $display("FAIL pack_ready[%0d]: got %b%b want 11", i, if0.host_tx_ready_o, if1.host_tx_ready_o); else passed++;
      checks++; if (if0.mcl_v_o !== 1'b0) $display("FAIL pack_early_v[%0d]: got %b want 0", i, if0.mcl_v_o); else passed++;
    end
    @(posedge clk); #1;
    if0.host_tx_v_i = 0; if1.host_tx_v_i = 0;
    @(negedge clk);
    checks++; if (if0.mcl_v_o !== 1'b1) $display("FAIL pack_v_lsb: got %b want 1", if0.mcl_v_o);
    else begin
      logic [127:0] e; e = txq0.pop_front();
      if (if0.mcl_data_o !== e) $display("FAIL pack_data_lsb: got %h want %h", if0.mcl_data_o, e); else passed++;
    end
    checks++; if (if1.mcl_v_o !== 1'b1) $display("FAIL pack_v_msb: got %b want 1", if1.mcl_v_o);
    else begin
      logic [127:0] e; e = txq1.pop_front();
      if (if1.mcl_data_o !== e) $display("FAIL pack_data_msb: got %h want %h", if1.mcl_data_o, e); else passed++;
    end
    @(posedge clk); @(negedge clk);
    checks++; if (if0.mcl_v_o !== 1'b0 || if1.mcl_v_o !== 1'b0) $display("FAIL pack_v_one_cycle: got %b%b want 00", if0.mcl_v_o, if1.mcl_v_o); else passed++;
  endtask

  task automatic test_tx_backpressure;
    int k;
    logic [127:0] e;
    k = 0;
    if0.mcl_r_i = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if0.host_tx_v_i = 1; if0.host_tx_data_i = word(32'h01010101, 32'h01010101, k);
      @(negedge clk);
      if (if0.host_tx_ready_o) begin
        if (k == 3) txq0.push_back(pack4(32'h01010101, 32'h01010101, 1'b1));
        k++;
      end
    end
    checks++; if (k != 7) $display("FAIL bp_accepted: got %0d want 7", k); else passed++;
    checks++; if (if0.host_tx_ready_o !== 1'b0) $display("FAIL bp_ready_word8: got %b want 0", if0.host_tx_ready_o); else passed++;
    checks++; if (if0.tx_words_pending_o !== 2'd3) $display("FAIL bp_pending: got %0d want 3", if0.tx_words_pending_o); else passed++;
    checks++; if (if0.mcl_v_o !== 1'b1 || txq0.size() != 1 || if0.mcl_data_o !== txq0[0]) $display("FAIL bp_held: v %b data %h", if0.mcl_v_o, if0.mcl_data_o); else passed++;
    @(posedge clk); #1;
    if0.mcl_r_i = 1;
    @(negedge clk);
    checks++; if (if0.host_tx_ready_o !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", if0.host_tx_ready_o);
    else begin passed++; txq0.push_back(pack4(32'h05050505, 32'h01010101, 1'b1)); end
    e = txq0.pop_front();
    checks++; if (if0.mcl_v_o !== 1'b1 || if0.mcl_data_o !== e) $display("FAIL bp_pkt1: v %b got %h want %h", if0.mcl_v_o, if0.mcl_data_o, e); else passed++;
    @(posedge clk); #1;
    if0.host_tx_v_i = 0;
    @(negedge clk);
    e = (txq0.size() > 0) ? txq0.pop_front() : '0;
    checks++; if (if0.mcl_v_o !== 1'b1 || if0.mcl_data_o !== e) $display("FAIL bp_pkt2: v %b got %h want %h", if0.mcl_v_o, if0.mcl_data_o, e); else passed++;
    checks++; if (if0.tx_words_pending_o !== 2'd0) $display("FAIL bp_pending_end: got %0d want 0", if0.tx_words_pending_o); else passed++;
    @(posedge clk); @(negedge clk);
    checks++; if (if0.mcl_v_o !== 1'b0) $display("FAIL bp_drained: got %b want 0", if0.mcl_v_o); else passed++;
  endtask

  task automatic test_tx_flush;
    logic [127:0] e;
    if0.mcl_r_i = 1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if0.host_tx_v_i = 1; if0.host_tx_data_i = word(32'h0F0F0F0F, 32'h1, i);
    end
    @(posedge clk); #1;
    if0.host_tx_data_i = 32'hDEADBEEF; if0.tx_flush_i = 1;
    @(negedge clk);
    checks++; if (if0.tx_words_pending_o !== 2'd2) $display("FAIL flush_pending_before: got %0d want 2", if0.tx_words_pending_o); else passed++;
    checks++; if (if0.host_tx_ready_o !== 1'b0) $display("FAIL flush_ready: got %b want 0", if0.host_tx_ready_o); else passed++;
    @(posedge clk); #1;
    if0.tx_flush_i = 0; if0.host_tx_v_i = 0;
    @(negedge clk);
    checks++; if (if0.tx_words_pending_o !== 2'd0 || if0.mcl_v_o !== 1'b0) $display("FAIL flush_after: pending %0d v %b want 0 0", if0.tx_words_pending_o, if0.mcl_v_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if0.host_tx_v_i = 1; if0.host_tx_data_i = word(32'h03030303, 32'h10, i);
      if (i == 3) txq0.push_back(pack4(32'h03030303, 32'h10, 1'b1));
    end
    @(posedge clk); #1;
    if0.host_tx_v_i = 0;
    @(negedge clk);
    e = txq0.pop_front();
    checks++; if (if0.mcl_v_o !== 1'b1 || if0.mcl_data_o !== e) $display("FAIL flush_next_pkt: v %b got %h want %h", if0.mcl_v_o, if0.mcl_data_o, e); else passed++;
  endtask

  task automatic test_rx_unpack;
    logic [31:0] e0, e1;
    @(posedge clk); #1;
    if0.mcl_v_i = 1; if0.mcl_data_i = pack4(32'hAAAAAAAA, 32'h11111111, 1'b1);
    if1.mcl_v_i = 1; if1.mcl_data_i = pack4(32'hAAAAAAAA, 32'h11111111, 1'b1);
    @(negedge clk);
    checks++; if (if0.mcl_r_o !== 1'b1 || if0.rcv_vacancy_o !== 9'd256) $display("FAIL rx_idle: r %b vac %0d want 1 256", if0.mcl_r_o, if0.rcv_vacancy_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      rxq0.push_back(word(32'hAAAAAAAA, 32'h11111111, i));
      rxq1.push_back(word(32'hAAAAAAAA, 32'h11111111, 3 - i));
    end
    @(posedge clk); #1;
    if0.mcl_v_i = 0; if0.host_rx_yumi_i = 1;
    if1.mcl_v_i = 0; if1.host_rx_yumi_i = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e0 = rxq0.pop_front(); e1 = rxq1.pop_front();
      checks++; if (if0.host_rx_v_o !== 1'b1 || if0.host_rx_data_o !== e0) $display("FAIL rx_word_lsb[%0d]: v %b got %h want %h", i, if0.host_rx_v_o, if0.host_rx_data_o, e0); else passed++;
      checks++; if (if1.host_rx_data_o !== e1) $display("FAIL rx_word_msb[%0d]: got %h want %h", i, if1.host_rx_data_o, e1); else passed++;
      checks++; if (if0.rcv_vacancy_o !== 9'd255) $display("FAIL rx_vac_busy[%0d]: got %0d want 255", i, if0.rcv_vacancy_o); else passed++;
      @(posedge clk); #1;
    end
    if0.host_rx_yumi_i = 0; if1.host_rx_yumi_i = 0;
    @(negedge clk);
    checks++; if (if0.rcv_vacancy_o !== 9'd256 || if0.host_rx_v_o !== 1'b0) $display("FAIL rx_vac_back: vac %0d v %b want 256 0", if0.rcv_vacancy_o, if0.host_rx_v_o); else passed++;
  endtask

  task automatic test_rx_full;
    int k;
    logic [31:0] e;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if2.mcl_v_i = 1; if2.mcl_data_i = pack4(32'hC0DE0000 + 32'(k) * 256, 32'h1, 1'b1);
      @(negedge clk);
      if (if2.mcl_r_o) begin
        for (int i = 0; i < 4; i++) rxq2.push_back(word(32'hC0DE0000 + 32'(k) * 256, 32'h1, i));
        k++;
      end
    end
    checks++; if (k != 4) $display("FAIL full_accepted: got %0d want 4", k); else passed++;
    checks++; if (if2.mcl_r_o !== 1'b0 || if2.rcv_vacancy_o !== 3'd0) $display("FAIL full_state: r %b vac %0d want 0 0", if2.mcl_r_o, if2.rcv_vacancy_o); else passed++;
    @(posedge clk); #1;
    if2.mcl_v_i = 0; if2.host_rx_yumi_i = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = rxq2.pop_front();
      checks++; if (if2.host_rx_data_o !== e) $display("FAIL full_drain0[%0d]: got %h want %h", i, if2.host_rx_data_o, e); else passed++;
      @(posedge clk); #1;
    end
    if2.host_rx_yumi_i = 0;
    @(negedge clk);
    checks++; if (if2.rcv_vacancy_o !== 3'd1 || if2.mcl_r_o !== 1'b1) $display("FAIL full_one_free: vac %0d r %b want 1 1", if2.rcv_vacancy_o, if2.mcl_r_o); else passed++;
    @(posedge clk); #1;
    if2.host_rx_yumi_i = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin if2.mcl_v_i = 1; if2.mcl_data_i = pack4(32'hC0DE0400, 32'h1, 1'b1); end
      @(negedge clk);
      e = rxq2.pop_front();
      checks++; if (if2.host_rx_data_o !== e) $display("FAIL full_drain1[%0d]: got %h want %h", i, if2.host_rx_data_o, e); else passed++;
      if (i == 3 && if2.mcl_r_o) for (int j = 0; j < 4; j++) rxq2.push_back(word(32'hC0DE0400, 32'h1, j));
      @(posedge clk); #1;
    end
    if2.host_rx_yumi_i = 0; if2.mcl_v_i = 0;
    @(negedge clk);
    checks++; if (if2.rcv_vacancy_o !== 3'd1) $display("FAIL full_simul_vac: got %0d want 1", if2.rcv_vacancy_o); else passed++;
    @(posedge clk); #1;
    if2.mcl_v_i = 1; if2.mcl_data_i = pack4(32'hC0DE0500, 32'h1, 1'b1);
    @(negedge clk);
    if (if2.mcl_r_o) for (int j = 0; j < 4; j++) rxq2.push_back(word(32'hC0DE0500, 32'h1, j));
    @(posedge clk); #1;
    if2.mcl_v_i = 0;
    @(negedge clk);
    checks++; if (if2.rcv_vacancy_o !== 3'd0 || if2.mcl_r_o !== 1'b0) $display("FAIL full_refill: vac %0d r %b want 0 0", if2.rcv_vacancy_o, if2.mcl_r_o); else passed++;
    @(posedge clk); #1;
    if2.host_rx_yumi_i = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e = (rxq2.size() > 0) ? rxq2.pop_front() : 32'hBAD0BAD0;
      checks++; if (if2.host_rx_v_o !== 1'b1 || if2.host_rx_data_o !== e) $display("FAIL full_final[%0d]: v %b got %h want %h", i, if2.host_rx_v_o, if2.host_rx_data_o, e); else passed++;
      @(posedge clk); #1;
    end
    if2.host_rx_yumi_i = 0;
    @(negedge clk);
    checks++; if (if2.rcv_vacancy_o !== 3'd4 || if2.host_rx_v_o !== 1'b0 || rxq2.size() != 0) $display("FAIL full_empty: vac %0d v %b left %0d want 4 0 0", if2.rcv_vacancy_o, if2.host_rx_v_o, rxq2.size()); else passed++;
  endtask

  task automatic test_ratio1;
    logic [31:0] e;
    if3.mcl_r_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        if3.host_tx_v_i = 1; if3.host_tx_data_i = word(32'h5A5A0000, 32'h3, i); txq3.push_back(word(32'h5A5A0000, 32'h3, i));
        if3.mcl_v_i = 1; if3.mcl_data_i = word(32'h7E7E0000, 32'h5, i);
      end else begin
        if3.host_tx_v_i = 0; if3.mcl_v_i = 0;
      end
      if3.host_rx_yumi_i = if3.host_rx_v_o;
      @(negedge clk);
      if (i < 4) begin
        checks++; if (if3.mcl_r_o !== 1'b1 || if3.host_tx_ready_o !== 1'b1) $display("FAIL r1_ready[%0d]: mcl_r %b tx_ready %b want 1 1", i, if3.mcl_r_o, if3.host_tx_ready_o);
        else begin passed++; rxq3.push_back(word(32'h7E7E0000, 32'h5, i)); end
      end
      if (i > 0) begin
        e = txq3.pop_front();
        checks++; if (if3.mcl_v_o !== 1'b1 || if3.mcl_data_o !== e) $display("FAIL r1_tx[%0d]: v %b got %h want %h", i, if3.mcl_v_o, if3.mcl_data_o, e); else passed++;
        e = (rxq3.size() > 0) ? rxq3.pop_front() : 32'hBAD0BAD0;
        checks++; if (if3.host_rx_v_o !== 1'b1 || if3.host_rx_data_o !== e) $display("FAIL r1_rx[%0d]: v %b got %h want %h", i, if3.host_rx_v_o, if3.host_rx_data_o, e); else passed++;
      end
      checks++; if (if3.tx_words_pending_o !== 1'b0) $display("FAIL r1_pending[%0d]: got %0d want 0", i, if3.tx_words_pending_o); else passed++;
    end
    @(posedge clk); #1;
    if3.host_rx_yumi_i = 0;
    @(negedge clk);
    checks++; if (if3.mcl_v_o !== 1'b0 || if3.host_rx_v_o !== 1'b0 || if3.rcv_vacancy_o !== 3'd4) $display("FAIL r1_idle: tx_v %b rx_v %b vac %0d want 0 0 4", if3.mcl_v_o, if3.host_rx_v_o, if3.rcv_vacancy_o); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tx_pack();
    test_tx_backpressure();
    test_tx_flush();
    test_rx_unpack();
    test_rx_full();
    test_ratio1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bsg_mcl_host_gearbox.md
Name: bsg_mcl_host_gearbox

Overview:
Parametrised host-word <-> MCL-packet gearbox between the 32-bit host FIFO interface (fed by bsg_axil_to_fifos) and the manycore link (MCL).
- TX: packs 32-bit host words into mcl_width_p packets.
- RX: buffers incoming MCL packets and unpacks them into 32-bit words.
- Generalises the fixed 32<->128 converter: any width ratio, selectable word order, partial-packet flush, exact credit/vacancy accounting, per-direction status counters.

Parameters:
mcl_width_p, 128, MCL packet width; must be a multiple of 32 and >= 32; ratio_lp = mcl_width_p/32.
rcv_els_p, 256, RX packet FIFO depth in packets; must be >= 2.
lsb_first_p, 1, 1: first host word maps to bits [31:0]; 0: first host word maps to bits [mcl_width_p-1 -: 32].

Ports:
clk_i  in  1  clock; all logic on rising edge.
reset_i  in  1  synchronous, active-high reset.
host_tx_v_i  in  1  host TX word valid.
host_tx_data_i  in  32  host TX word.
host_tx_ready_o  out  1  TX word accepted when v&ready.
tx_flush_i  in  1  discard the partially assembled TX packet.
mcl_v_o  out  1  packet valid to MCL.
mcl_data_o  out  mcl_width_p  packet to MCL.
mcl_r_i  in  1  MCL ready; transfer on v&r.
mcl_v_i  in  1  packet valid from MCL.
mcl_data_i  in  mcl_width_p  packet from MCL.
mcl_r_o  out  1  RX FIFO can accept a packet.
host_rx_v_o  out  1  RX word valid.
host_rx_data_o  out  32  RX word.
host_rx_yumi_i  in  1  host consumes RX word; legal only when host_rx_v_o=1.
rcv_vacancy_o  out  $clog2(rcv_els_p+1)  free RX packet slots.
tx_words_pending_o  out  $clog2(ratio_lp)  (min width 1)  words held in the TX assembly buffer.

Behaviour:
Reset values: mcl_v_o=0, host_rx_v_o=0, rcv_vacancy_o=rcv_els_p, tx_words_pending_o=0, mcl_r_o=1 on the first cycle after reset.

TX path:
- Assembly buffer holds ratio_lp-1 words plus a word counter tx_cnt (0..ratio_lp-1).
- A separate output register holds one packet.
- Accepting a word with tx_cnt<ratio_lp-1 stores it at slot tx_cnt and increments tx_cnt.
- Accepting a word with tx_cnt=ratio_lp-1 loads the output register with {assembly, word} ordered per lsb_first_p, sets out_v, and resets tx_cnt to 0.
- mcl_v_o appears the cycle after the last word. Latency: last word -> mcl_v_o = 1 cycle.
- host_tx_ready_o = ~tx_flush_i & ( (tx_cnt!=ratio_lp-1) | ~out_v | mcl_r_i ). Sustained throughput is 1 word/cycle with no bubbles.
- out_v clears on mcl_v_o&mcl_r_i unless a new packet loads in the same cycle, in which case out_v stays 1 and the new data replaces the old.
- tx_flush_i: tx_cnt <= 0 and the assembly buffer is discarded. The output register is unaffected. A word presented in the same cycle is not accepted (ready=0).
- ratio_lp=1: no assembly buffer; each word loads the output register directly; tx_words_pending_o is tied to 0.
- tx_words_pending_o = tx_cnt.

RX path:
- Packet FIFO of depth rcv_els_p (bsg_fifo_1r1w_small, ready-then-valid=0).
- mcl_r_o = FIFO ready_o; enqueue = mcl_v_i & mcl_r_o.
- Word index rx_idx counts 0..ratio_lp-1.
- host_rx_v_o = FIFO v_o.
- host_rx_data_o = head packet slice rx_idx, ordered per lsb_first_p.
- On host_rx_yumi_i: rx_idx increments. At ratio_lp-1, the FIFO head is dequeued and rx_idx returns to 0.
- Latency: enqueued packet -> host_rx_v_o = 1 cycle.

Vacancy:
- rcv_vacancy_o decrements on enqueue and increments on packet dequeue (last word yumi only).
- Simultaneous enqueue and dequeue: value unchanged.
- Range is always 0..rcv_els_p.
- rcv_vacancy_o=0 exactly when mcl_r_o=0.

Boundary conditions:
- Full FIFO: mcl_r_o=0 and the MCL must hold.
- Empty FIFO: host_rx_v_o=0 and host_rx_yumi_i is ignored (flagged as an assertion error).
- Reset mid-operation drops the partial TX packet, the output register, all RX contents and rx_idx.
- Elaboration assertion: mcl_width_p%32==0.

Decomposition:
Shared package bsg_mcl_gearbox_pkg:
- host_word_width_gp=32.
- Function mcl_ratio(width).
- Slice-select function word_slice(packet, idx, lsb_first).

One natural sub-module: bsg_mcl_word_packer (TX assembly buffer, tx_cnt, output register, flush). The RX side instantiates the existing bsg_fifo_1r1w_small plus inline rx_idx and vacancy logic.

Test Plan:
1. Reset: after reset_i, rcv_vacancy_o=256, mcl_v_o=0, host_rx_v_o=0, mcl_r_o=1.
2. TX packing, lsb_first_p=1: words 0x11111111, 0x22222222, 0x33333333, 0x44444444 on back-to-back cycles with mcl_r_i=1 -> one cycle later mcl_data_o=0x44444444_33333333_22222222_11111111, mcl_v_o high for exactly 1 cycle. With lsb_first_p=0 the order is reversed.
3. TX backpressure and flush:
   - mcl_r_i=0 with 8 words offered -> the first packet is held. Words 5-7 are accepted (tx_words_pending_o=3), then host_tx_ready_o=0 on word 8 until mcl_r_i=1.
   - Separately, 2 words then tx_flush_i -> tx_words_pending_o=0, no packet emitted.
4. RX unpacking: packet 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA with constant yumi -> host_rx_data_o AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD on consecutive cycles. rcv_vacancy_o goes 256->255, then back to 256 after the 4th yumi.
5. RX full: rcv_els_p=4, host yumi held 0, 6 packets offered -> 4 accepted, mcl_r_o=0, rcv_vacancy_o=0. Consume 4 words -> vacancy=1, the 5th packet enqueues; with simultaneous enqueue and dequeue the vacancy stays constant.
6. Ratio 1 (mcl_width_p=32): words pass through with 1-cycle latency on TX and RX. tx_words_pending_o stays 0.
